// File: rtl/karatsuba_dot_acc_if.sv
// Operand stream and result handshake bundle for karatsuba_dot_acc.
// Master is the producer/consumer side, slave is the accumulator.
interface karatsuba_dot_acc_if #(
    parameter int ACC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_sum
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/karatsuba_dot_acc.sv
// Karatsuba 8x8 multiplier feeding a flow-controlled LEN-term
// dot-product accumulator with a held result handshake.
module karatsuba_mult_8 (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] p_o
);
    logic [3:0]  ah, al, bh, bl;
    logic [4:0]  sa, sb;
    logic [7:0]  z0, z2;
    logic [9:0]  zm;
    logic [15:0] z1;

    assign ah = a_i[7:4];
    assign al = a_i[3:0];
    assign bh = b_i[7:4];
    assign bl = b_i[3:0];
    assign sa = 5'(ah) + 5'(al);
    assign sb = 5'(bh) + 5'(bl);
    assign z2 = 8'(ah) * 8'(bh);
    assign z0 = 8'(al) * 8'(bl);
    assign zm = 10'(sa) * 10'(sb);
    // Cross term recovered from the sum product; never negative.
    assign z1 = 16'(zm) - 16'(z2) - 16'(z0);
    assign p_o = {z2, 8'b0} + (z1 << 4) + 16'(z0);
endmodule

module karatsuba_dot_acc #(
    parameter int LEN   = 4,
    parameter int ACC_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    karatsuba_dot_acc_if.slave bus
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {
        S_ACC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      prod;
    logic [15:0]      p_reg_q;
    logic             p_vld_q;
    logic             p_first_q;
    logic [ACC_W-1:0] acc_q;
    logic             accept;
    logic             in_rdy;
    logic             out_vld;

    karatsuba_mult_8 u_mult (
        .a_i (bus.a),
        .b_i (bus.b),
        .p_o (prod)
    );

    assign accept = bus.in_valid && (state_q == S_ACC);

    // Next-state, beat count and handshake outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        unique case (state_q)
            S_ACC: begin
                in_rdy = 1'b1;
                if (accept) begin
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // FSM state and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ACC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Product stage: capture product and tag the first beat of a vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg_q   <= '0;
            p_vld_q   <= 1'b0;
            p_first_q <= 1'b0;
        end else begin
            p_vld_q   <= accept;
            p_first_q <= accept && (cnt_q == '0);
            if (accept) begin
                p_reg_q <= prod;
            end
        end
    end

    // Accumulate; the first product of a vector restarts the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (p_vld_q) begin
            if (p_first_q) begin
                acc_q <= ACC_W'(p_reg_q);
            end else begin
                acc_q <= acc_q + ACC_W'(p_reg_q);
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.out_sum   = acc_q;
endmodule

// File: doc/karatsuba_dot_acc.md
# karatsuba_dot_acc

Sequential dot-product stage built around the 8-bit Karatsuba multiplier (`karatsuba_mult_8`). It accepts a stream of unsigned 8-bit operand pairs over a valid/ready handshake and multiplies each pair in a registered product stage. It accumulates LEN products into one sum and presents the sum on a held valid/ready output. It sits directly downstream of the multiplier and turns its combinational 16-bit products into a pipelined, flow-controlled accumulator for filter/MAC datapaths.

## Interface
- LEN, 4: products per dot product; legal range 2..256.
- ACC_W, 32: accumulator and output width; must be ≥ 16 + clog2(LEN).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept a pair; a beat transfers when in_valid && in_ready at a rising edge.
- a  input  8  unsigned operand.
- b  input  8  unsigned operand.
- out_valid  output  1  out_sum holds a completed dot product.
- out_ready  input  1  consumer takes the result; the result transfers when out_valid && out_ready at a rising edge.
- out_sum  output  ACC_W  accumulated sum; only meaningful while out_valid = 1.

## Operation
- One `karatsuba_mult_8` instance computes a×b combinationally from the input port.
- Product register p_reg[15:0] loads the product on every accepted beat.
  - p_vld flag: set on an accepted beat, cleared otherwise.
  - p_first flag: set for beat 0 of a vector.
- Beat counter cnt, 0..LEN-1, counts accepted beats within the current vector.
- FSM states:
  - ACC: in_ready = 1. Each accepted beat increments cnt. When the accepted beat has cnt = LEN-1, cnt wraps to 0 and the FSM goes to DRAIN.
  - DRAIN: in_ready = 0. The last product is still in p_reg. On the next edge it is accumulated, the FSM goes to DONE, and out_valid is set.
  - DONE: in_ready = 0, out_valid = 1. On out_valid && out_ready the FSM goes to ACC and out_valid clears.
- Accumulator update (on edges where p_vld = 1): acc <= p_first ? zero-extended p_reg : acc + zero-extended p_reg.
  - No separate clear is needed; p_first restarts the sum.
- Arithmetic is unsigned only. With legal ACC_W no overflow can occur.
- out_sum is wired directly to acc.
- Gaps (in_valid low) in ACC are allowed anywhere in a vector. Nothing advances on a gap, and p_vld = 0 on the following cycle.
- in_valid is ignored in DRAIN and DONE. a and b are don't-care unless in_valid && in_ready.

## Timing
- Reset values (rst_n low, asynchronous):
  - FSM = ACC, so in_ready = 1 once reset is released.
  - out_valid = 0.
  - out_sum/acc = 0.
  - cnt = 0.
  - p_vld = 0, p_reg = 0.
- Latency: for a last beat accepted at edge k, the product is in p_reg after edge k. acc includes it and out_valid = 1 after edge k+1, i.e. 2 cycles.
- Throughput: one beat per cycle within a vector. Minimum cost per vector is LEN + 2 cycles, including the output handshake cycle when out_ready = 1.
- Output hold: while out_valid = 1 and out_ready = 0, out_sum and out_valid stay stable for any duration.
- After the output handshake at edge m, in_ready = 1 in the cycle following edge m.
- Reset mid-operation: any partial sum, pending product or held result is discarded. The first beat after reset starts a new vector with cnt = 0.
- Simultaneous events:
  - out_ready is a don't-care while out_valid = 0.
  - in_valid high during DRAIN/DONE is not accepted; the upstream stage must hold its data.

## Test plan
- LEN=4, back-to-back beats (1,2),(3,4),(5,6),(7,8) with out_ready = 1 -> out_valid pulses once, 2 cycles after the 4th beat, with out_sum = 100; in_ready is low for exactly 2 cycles.
- LEN=4, four beats (255,255) -> out_sum = 260100 (0x3F804). Then (240,15)×4 -> out_sum = 14400, with no carry-over from the previous vector.
- Backpressure: hold out_ready = 0 for 6 cycles after out_valid rises, with in_valid held high -> out_sum stays constant, in_ready = 0, no beats accepted. Release out_ready -> one transfer, then in_ready = 1 the next cycle.
- Input gaps: vector (10,10),(0,200),(20,3),(1,1) with 1-3 idle cycles between beats -> out_sum = 161; cnt and acc unchanged during gaps.
- Reset mid-vector: accept (9,9),(9,9), pulse rst_n low for 1 cycle -> out_valid = 0, out_sum = 0, in_ready = 1. Then (2,3)×4 -> out_sum = 24.
- Two vectors of (1,1)×4 and (2,2)×4 with out_ready = 1 throughout -> results 4 then 16, with exactly LEN + 2 cycles between out_valid pulses.
